// File: rtl/mul32_sequencer.sv
// mul32_sequencer: unsigned 2W x 2W -> 4W multiplier built by time-sharing one
// external W x W -> 2W combinational multiplier. The operands are latched on
// acceptance. Four partial products are then issued in the fixed order
// aL*bL, aH*bL, aL*bH, aH*bH, and their shifted values are summed in a 4W
// accumulator. If either operand is zero, the block skips the passes and goes
// straight to DONE with a zero result.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_ready is high only in IDLE
//   in_a, in_b            2W-bit unsigned operands
//   out_valid/out_ready   result handshake; out_valid is high only in DONE
//   out_result            4W-bit product, held until the next load
//   mul_a, mul_b          W-bit operands to the shared multiplier (0 when unused)
//   mul_p                 2W-bit product from the shared multiplier, same cycle
//   busy                  high in every state except IDLE
module mul32_sequencer #(
  parameter int unsigned W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_a,
  input  logic [2*W-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*W-1:0]   out_result,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_p,
  output logic             busy
);

  localparam int unsigned OpW  = 2 * W;
  localparam int unsigned AccW = 4 * W;

  typedef enum logic [2:0] {
    StIdle,
    StPp0,
    StPp1,
    StPp2,
    StPp3,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [OpW-1:0]    a_q, a_d;
  logic [OpW-1:0]    b_q, b_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [AccW-1:0]   result_q, result_d;

  logic [W-1:0]      a_lo, a_hi, b_lo, b_hi;
  logic [AccW-1:0]   pp_ext;

  assign a_lo = a_q[W-1:0];
  assign a_hi = a_q[OpW-1:W];
  assign b_lo = b_q[W-1:0];
  assign b_hi = b_q[OpW-1:W];

  // Partial product zero-extended to accumulator width before shifting.
  assign pp_ext = {{OpW{1'b0}}, mul_p};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    mul_a    = '0;
    mul_b    = '0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          acc_d = '0;
          if ((in_a == '0) || (in_b == '0)) begin
            // Zero fast path: the product is known without any passes.
            result_d = '0;
            state_d  = StDone;
          end else begin
            state_d = StPp0;
          end
        end
      end
      StPp0: begin
        mul_a   = a_lo;
        mul_b   = b_lo;
        acc_d   = pp_ext;
        state_d = StPp1;
      end
      StPp1: begin
        mul_a   = a_hi;
        mul_b   = b_lo;
        acc_d   = acc_q + (pp_ext << W);
        state_d = StPp2;
      end
      StPp2: begin
        mul_a   = a_lo;
        mul_b   = b_hi;
        acc_d   = acc_q + (pp_ext << W);
        state_d = StPp3;
      end
      StPp3: begin
        mul_a    = a_hi;
        mul_b    = b_hi;
        // The last pass goes straight into the result register, so DONE
        // never depends on the accumulator.
        result_d = acc_q + (pp_ext << OpW);
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;

endmodule

// File: tb/tb_mul32_sequencer.sv
module tb_mul32_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_p;
  logic        busy;

  int n_cmp;
  int n_fail;

  // Shared 16x16 combinational multiplier.
  assign mul_p = {16'b0, mul_a} * {16'b0, mul_b};

  mul32_sequencer #(.W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Runs one transaction from IDLE with out_ready high. Starts and ends on a negedge.
  // lat counts edges from accept (inclusive) until out_valid is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output bit ok);
    int guard;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ok  = out_valid && (guard < 20);
    res = out_result;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 64'd0 ||
        mul_a !== 16'd0 || mul_b !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b busy=%b result=%h mul=%h/%h, want 1 0 0 0 0/0",
               in_ready, out_valid, busy, out_result, mul_a, mul_b);
    end
  endtask

  task automatic test_seq_3x5();
    logic [15:0] ea [4];
    logic [15:0] eb [4];
    ea[0] = 16'd3; ea[1] = 16'd0; ea[2] = 16'd3; ea[3] = 16'd0;
    eb[0] = 16'd5; eb[1] = 16'd5; eb[2] = 16'd0; eb[3] = 16'd0;
    in_a = 32'd3; in_b = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mul_a !== ea[i] || mul_b !== eb[i] || busy !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL seq3x5_pass%0d: got mul=%0d/%0d busy=%b ov=%b, want %0d/%0d busy=1 ov=0",
                 i, mul_a, mul_b, busy, out_valid, ea[i], eb[i]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== 64'h000000000000000F) begin
      n_fail++;
      $display("FAIL seq3x5_done: got ov=%b result=%h, want ov=1 result=000000000000000f",
               out_valid, out_result);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL seq3x5_idle: got in_ready=%b ov=%b busy=%b, want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_corners();
    logic [63:0] res;
    int lat;
    bit ok;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, ok);
    n_cmp++;
    if (!ok || res !== 64'hFFFFFFFE00000001 || lat != 5) begin
      n_fail++;
      $display("FAIL corner_max: got ok=%b result=%h lat=%0d, want result=fffffffe00000001 lat=5",
               ok, res, lat);
    end
    run_op(32'h00010000, 32'h00010000, res, lat, ok);
    n_cmp++;
    if (!ok || res !== 64'h0000000100000000 || lat != 5) begin
      n_fail++;
      $display("FAIL corner_hi: got ok=%b result=%h lat=%0d, want result=0000000100000000 lat=5",
               ok, res, lat);
    end
    run_op(32'h0, 32'h1234, res, lat, ok);
    n_cmp++;
    if (!ok || res !== 64'd0 || lat != 1) begin
      n_fail++;
      $display("FAIL corner_zero: got ok=%b result=%h lat=%0d, want result=0 lat=1", ok, res, lat);
    end
  endtask

  task automatic test_random();
    logic [63:0] res;
    logic [31:0] a, b;
    int lat, exp_lat, sel;
    bit ok;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) a = '0;
      if (sel == 1) b = '0;
      if (sel == 2) a = a & 32'h0000FFFF;
      if (sel == 3) b = b & 32'hFFFF0000;
      exp_lat = (a == 0 || b == 0) ? 1 : 5;
      run_op(a, b, res, lat, ok);
      n_cmp++;
      if (!ok || res !== ref_mul(a, b) || lat != exp_lat) begin
        n_fail++;
        $display("FAIL random_%0d: %h*%h got ok=%b result=%h lat=%0d, want %h lat=%0d",
                 i, a, b, ok, res, lat, ref_mul(a, b), exp_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, pa, pb;
    logic [63:0] hold;
    int guard;
    a = $urandom | 32'h1; b = $urandom | 32'h10000;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== ref_mul(a, b)) begin
      n_fail++;
      $display("FAIL bp_first: got ov=%b result=%h, want ov=1 result=%h",
               out_valid, out_result, ref_mul(a, b));
    end
    hold = ref_mul(a, b);
    pa = '0; pb = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pa = $urandom | 32'h100; pb = $urandom | 32'h3;
      in_a = pa; in_b = pb;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== hold || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got ov=%b result=%h in_ready=%b, want ov=1 result=%h in_ready=0",
                 i, out_valid, out_result, in_ready, hold);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got in_ready=%b ov=%b, want in_ready=1 ov=0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== ref_mul(pa, pb)) begin
      n_fail++;
      $display("FAIL bp_pending: got ov=%b result=%h, want ov=1 result=%h",
               out_valid, out_result, ref_mul(pa, pb));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int t0, t1, seen, guard;
    a = $urandom | 32'h10001; b = $urandom | 32'h10001;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    t0 = 0; t1 = 0; seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid && seen < 2) begin
        n_cmp++;
        if (out_result !== ref_mul(a, b)) begin
          n_fail++;
          $display("FAIL b2b_result: got %h, want %h", out_result, ref_mul(a, b));
        end
        if (seen == 0) t0 = c; else t1 = c;
        seen++;
      end
    end
    n_cmp++;
    if (seen != 2 || (t1 - t0) != 6) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d results period=%0d, want 2 results period=6",
               seen, t1 - t0);
    end
    in_valid = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    logic [63:0] res;
    int lat;
    bit ok;
    a = $urandom | 32'h10001; b = $urandom | 32'h10001;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || mul_a !== a[15:0] || mul_b !== b[31:16]) begin
      n_fail++;
      $display("FAIL midrst_pp2: got busy=%b mul=%h/%h, want busy=1 mul=%h/%h",
               busy, mul_a, mul_b, a[15:0], b[31:16]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 64'd0 ||
        mul_a !== 16'd0 || mul_b !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_async: got busy=%b ov=%b result=%h mul=%h/%h, want 0 0 0 0/0",
               busy, out_valid, out_result, mul_a, mul_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_release: got in_ready=%b ov=%b, want 1 0", in_ready, out_valid);
    end
    run_op(32'd7, 32'd9, res, lat, ok);
    n_cmp++;
    if (!ok || res !== 64'd63 || lat != 5) begin
      n_fail++;
      $display("FAIL midrst_7x9: got ok=%b result=%0d lat=%0d, want 63 lat=5", ok, res, lat);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_seq_3x5();
    test_corners();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
